updown_mod_counter: RTL and testbench

Synchronous, parametrised up/down counter with programmable modulus, step size, parallel load, synchronous clear and wrap/saturate mode. It generalises the team's fixed-width asynchronous ripple up/down counter into a single-clock-domain block. All flops share one clock, which avoids ripple skew. It adds terminal-count and overflow/underflow reporting for use as a timer or prescaler in larger sequential designs.

---
 rtl/updown_mod_counter.sv | 100 ++++++++++
 tb/tb_updown_mod_counter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// Purpose : synchronous up/down counter, range 0..MOD-1, with step, load, clear and wrap/saturate policy.
// Latency : q, ovf and unf update one clk edge after the controlling inputs; tc is combinational from q and mode.
// Backpressure: none; en gates counting and the block accepts a new command on every cycle.
//
// Ports:
//   clk, rst      - clock and asynchronous active-high reset (q=0, ovf=0, unf=0)
//   clr, load     - synchronous clear / parallel load of din (din clamped to MOD-1)
//   din           - load value
//   en, mode, sat - count enable, direction (1=up, 0=down), boundary policy (1=saturate, 0=wrap)
//   q             - registered count
//   tc            - terminal count for the current direction
//   ovf, unf      - registered one-cycle pulses on up / down boundary events
module updown_mod_counter #(
   parameter int N    = 4,
   parameter int MOD  = 16,
   parameter int STEP = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         load,
   input  logic [N-1:0] din,
   input  logic         en,
   input  logic         mode,
   input  logic         sat,
   output logic [N-1:0] q,
   output logic         tc,
   output logic         ovf,
   output logic         unf
);

   localparam int MOD_M1  = MOD - 1;
   localparam int DN_WRAP = MOD - STEP;

   // Up-count comparison runs in N+1 bits so q+STEP cannot alias when MOD=2**N.
   localparam logic [N:0]   STEP_X  = STEP[N:0];
   localparam logic [N:0]   MAX_X   = MOD_M1[N:0];
   localparam logic [N-1:0] MAX_Q   = MOD_M1[N-1:0];
   localparam logic [N-1:0] MOD_LO  = MOD[N-1:0];
   localparam logic [N-1:0] STEP_LO = STEP[N-1:0];
   localparam logic [N-1:0] DNW_LO  = DN_WRAP[N-1:0];

   logic [N-1:0] q_q, q_d;
   logic         ovf_q, ovf_d;
   logic         unf_q, unf_d;

   logic [N:0]   q_ext;
   logic [N:0]   up_sum;

   always_comb begin
      q_ext  = {1'b0, q_q};
      up_sum = q_ext + STEP_X;

      q_d   = q_q;
      ovf_d = 1'b0;
      unf_d = 1'b0;

      if (clr) begin
         q_d = '0;
      end else if (load) begin
         q_d = ({1'b0, din} > MAX_X) ? MAX_Q : din;
      end else if (en) begin
         if (mode) begin
            if (up_sum <= MAX_X) begin
               q_d = up_sum[N-1:0];
            end else begin
               // Every blocked or clamped attempt is an overflow event, even at MOD-1 already.
               ovf_d = 1'b1;
               // Results stay below MOD <= 2**N, so wrap arithmetic is exact in N bits.
               q_d   = sat ? MAX_Q : (up_sum[N-1:0] - MOD_LO);
            end
         end else begin
            if (q_ext >= STEP_X) begin
               q_d = q_q - STEP_LO;
            end else begin
               unf_d = 1'b1;
               q_d   = sat ? '0 : (q_q + DNW_LO);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q   <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         q_q   <= q_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign q   = q_q;
   assign ovf = ovf_q;
   assign unf = unf_q;
   assign tc  = mode ? (q_q == MAX_Q) : (q_q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
module tb_updown_mod_counter;

   logic       clk = 1'b0;
   logic       rst, clr, load, en, mode, sat;
   logic [3:0] din;

   logic [3:0] dq   [3];
   logic       dtc  [3];
   logic       dovf [3];
   logic       dunf [3];

   // Reference state: plain integers, one entry per DUT configuration.
   int mods  [3];
   int steps [3];
   int mq    [3];
   bit movf  [3];
   bit munf  [3];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   updown_mod_counter #(.N(4), .MOD(10), .STEP(1)) u0 (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din), .en(en), .mode(mode), .sat(sat),
      .q(dq[0]), .tc(dtc[0]), .ovf(dovf[0]), .unf(dunf[0]));

   updown_mod_counter #(.N(4), .MOD(10), .STEP(3)) u1 (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din), .en(en), .mode(mode), .sat(sat),
      .q(dq[1]), .tc(dtc[1]), .ovf(dovf[1]), .unf(dunf[1]));

   updown_mod_counter #(.N(4), .MOD(16), .STEP(1)) u2 (
      .clk(clk), .rst(rst), .clr(clr), .load(load), .din(din), .en(en), .mode(mode), .sat(sat),
      .q(dq[2]), .tc(dtc[2]), .ovf(dovf[2]), .unf(dunf[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mq[i]   = 0;
         movf[i] = 1'b0;
         munf[i] = 1'b0;
      end
   endtask

   // Next state from the behavioural rules with ordinary integer arithmetic.
   task automatic model_edge();
      for (int i = 0; i < 3; i++) begin
         int nq;
         bit o;
         bit u;
         nq = mq[i];
         o  = 1'b0;
         u  = 1'b0;
         if (clr) begin
            nq = 0;
         end else if (load) begin
            nq = (int'(din) > mods[i] - 1) ? mods[i] - 1 : int'(din);
         end else if (en) begin
            if (mode) begin
               if (mq[i] + steps[i] < mods[i]) nq = mq[i] + steps[i];
               else begin
                  o  = 1'b1;
                  nq = sat ? mods[i] - 1 : mq[i] + steps[i] - mods[i];
               end
            end else begin
               if (mq[i] >= steps[i]) nq = mq[i] - steps[i];
               else begin
                  u  = 1'b1;
                  nq = sat ? 0 : mq[i] + mods[i] - steps[i];
               end
            end
         end
         mq[i]   = nq;
         movf[i] = o;
         munf[i] = u;
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 3; i++) begin
         bit etc;
         etc = mode ? (mq[i] == mods[i] - 1) : (mq[i] == 0);
         chk($sformatf("%s.u%0d.q", tag, i),   dq[i],   mq[i]);
         chk($sformatf("%s.u%0d.ovf", tag, i), dovf[i], movf[i]);
         chk($sformatf("%s.u%0d.unf", tag, i), dunf[i], munf[i]);
         chk($sformatf("%s.u%0d.tc", tag, i),  dtc[i],  etc);
      end
   endtask

   // Inputs are stable across the edge; outputs are sampled 1 time unit later.
   task automatic tick(input string tag);
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      check_all(tag);
   endtask

   initial begin
      mods  = '{10, 10, 16};
      steps = '{1, 3, 1};
      model_reset();

      rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; mode = 1'b0; sat = 1'b0; din = 4'd0;
      #2;
      check_all("reset");
      @(posedge clk);
      #1;
      check_all("reset_hold");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all("post_reset");
      mode = 1'b1;
      #1;
      check_all("tc_mode_flip");

      // Up count with wrap.
      en = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick("up_wrap");
         if (k == 9) chk("p1_tc_at_9", dtc[0], 1);
         if (k == 10) begin
            chk("p1_wrap_q", dq[0], 0);
            chk("p1_wrap_ovf", dovf[0], 1);
         end
      end

      // Down count from zero with wrap.
      clr = 1'b1;
      tick("clr");
      clr = 1'b0; mode = 1'b0;
      tick("down_wrap");
      chk("p2_q9", dq[0], 9);
      chk("p2_unf", dunf[0], 1);
      repeat (3) tick("down");
      chk("p2_q6", dq[0], 6);

      // Saturate up, then reverse.
      sat = 1'b1; mode = 1'b1;
      repeat (12) tick("sat_up");
      chk("p3_hold_q", dq[0], 9);
      chk("p3_hold_ovf", dovf[0], 1);
      mode = 1'b0;
      repeat (2) tick("sat_rev");
      chk("p3_rev_q", dq[0], 7);
      chk("p3_rev_ovf", dovf[0], 0);

      // STEP=3 up and down.
      sat = 1'b0; clr = 1'b1;
      tick("clr2");
      clr = 1'b0; mode = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick("step3_up");
         if (k == 4) begin
            chk("p4_wrap_q", dq[1], 2);
            chk("p4_wrap_ovf", dovf[1], 1);
         end
      end
      chk("p4_q5", dq[1], 5);
      load = 1'b1; din = 4'd1;
      tick("load1");
      load = 1'b0; mode = 1'b0;
      tick("step3_down");
      chk("p4_down_q", dq[1], 8);
      chk("p4_down_unf", dunf[1], 1);

      // Priority and load clamp.
      clr = 1'b1; load = 1'b1; din = 4'd5; en = 1'b1;
      tick("prio");
      chk("p5_prio_q", dq[0], 0);
      clr = 1'b0; din = 4'd12;
      tick("clamp");
      chk("p5_clamp_q", dq[0], 9);
      chk("p5_noclamp_q16", dq[2], 12);
      chk("p5_clamp_ovf", dovf[0], 0);

      // Asynchronous reset mid-cycle.
      din = 4'd6; en = 1'b0;
      tick("load6");
      load = 1'b0; en = 1'b1; mode = 1'b1; sat = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      tick("rst_over_edge");
      #2;
      rst = 1'b0;
      tick("resume1");
      chk("p6_q1", dq[0], 1);
      tick("resume2");
      chk("p6_q2", dq[0], 2);

      // Randomised traffic against the reference.
      for (int k = 0; k < 400; k++) begin
         clr  = ($urandom_range(0, 15) == 0);
         load = ($urandom_range(0, 7) == 0);
         din  = 4'($urandom_range(0, 15));
         en   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 5) == 0) mode = ~mode;
         sat  = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 49) == 0) begin
            rst = 1'b1;
            #1;
            model_reset();
            check_all("rand_rst");
            rst = 1'b0;
         end
         tick("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
